// File: rtl/np_operand_feeder.sv
// np_operand_feeder: streams a layer's activations, weights and thresholds chunk by chunk to one neuron processor
module np_operand_feeder #(
    parameter int PARALLEL_INPUTS = 8,
    parameter int NUM_INPUTS      = 784,
    parameter int NUM_NEURONS     = 256,
    parameter int THRESH_W        = 32,
    localparam int CHUNKS  = (NUM_INPUTS + PARALLEL_INPUTS - 1) / PARALLEL_INPUTS,
    localparam int WADDR_W = (NUM_NEURONS * CHUNKS > 1) ? $clog2(NUM_NEURONS * CHUNKS) : 1,
    localparam int NADDR_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int CADDR_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    input  logic                       act_wr_en,
    input  logic [CADDR_W-1:0]         act_wr_addr,
    input  logic [PARALLEL_INPUTS-1:0] act_wr_data,
    output logic                       wt_rd_en,
    output logic [WADDR_W-1:0]         wt_addr,
    input  logic [PARALLEL_INPUTS-1:0] wt_rdata,
    output logic                       thr_rd_en,
    output logic [NADDR_W-1:0]         thr_addr,
    input  logic [THRESH_W-1:0]        thr_rdata,
    input  logic                       rd_en,
    output logic [PARALLEL_INPUTS-1:0] inputs,
    output logic [PARALLEL_INPUTS-1:0] weights,
    output logic [THRESH_W-1:0]        threshold,
    output logic                       inputs_valid,
    output logic                       weights_valid
);
    localparam int VALID_LAST = NUM_INPUTS - (CHUNKS - 1) * PARALLEL_INPUTS;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, DONE} state_t;

    state_t                     state_q, state_d;
    logic [NADDR_W-1:0]         neuron_q, neuron_d;
    logic [CADDR_W-1:0]         chunk_q, chunk_d;
    logic [WADDR_W-1:0]         wt_addr_q, wt_addr_d;
    logic [PARALLEL_INPUTS-1:0] inputs_q, inputs_d;
    logic [PARALLEL_INPUTS-1:0] weights_q, weights_d;
    logic                       valid_q, valid_d;
    logic [THRESH_W-1:0]        threshold_q, threshold_d;
    logic [THRESH_W-1:0]        thr_shadow_q, thr_shadow_d;
    logic [PARALLEL_INPUTS-1:0] act_q [CHUNKS];
    logic [PARALLEL_INPUTS-1:0] pad_mask;
    logic [PARALLEL_INPUTS-1:0] pad;
    logic                       first_chunk, last_chunk, last_neuron, act_we;

    // bits of the last chunk beyond NUM_INPUTS are padding
    for (genvar g = 0; g < PARALLEL_INPUTS; g++) begin : g_pad
        assign pad_mask[g] = (g >= VALID_LAST);
    end

    assign first_chunk   = (chunk_q == '0);
    assign last_chunk    = (chunk_q == CADDR_W'(CHUNKS - 1));
    assign last_neuron   = (neuron_q == NADDR_W'(NUM_NEURONS - 1));
    assign pad           = last_chunk ? pad_mask : '0;
    assign act_we        = act_wr_en && (state_q == IDLE) && (32'(act_wr_addr) < CHUNKS);

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign wt_rd_en      = (state_q == FETCH);
    assign thr_rd_en     = wt_rd_en && first_chunk;
    assign wt_addr       = wt_addr_q;
    assign thr_addr      = neuron_q;
    assign inputs        = inputs_q;
    assign weights       = weights_q;
    assign threshold     = threshold_q;
    assign inputs_valid  = valid_q;
    assign weights_valid = valid_q;

    // activation buffer survives reset so a layer can be replayed after an abort
    always_ff @(posedge clk) begin
        if (act_we) act_q[act_wr_addr] <= act_wr_data;
    end

    // sequencer: fetch, wait for memory, present until the processor takes the chunk
    always_comb begin
        state_d      = state_q;
        neuron_d     = neuron_q;
        chunk_d      = chunk_q;
        wt_addr_d    = wt_addr_q;
        inputs_d     = inputs_q;
        weights_d    = weights_q;
        valid_d      = valid_q;
        threshold_d  = threshold_q;
        thr_shadow_d = thr_shadow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FETCH;
                    neuron_d  = '0;
                    chunk_d   = '0;
                    wt_addr_d = '0;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                inputs_d  = act_q[chunk_q] & ~pad;
                weights_d = wt_rdata | pad;
                valid_d   = 1'b1;
                if (first_chunk) thr_shadow_d = thr_rdata;
                state_d   = PRESENT;
            end
            PRESENT: begin
                if (rd_en) begin
                    valid_d   = 1'b0;
                    wt_addr_d = wt_addr_q + WADDR_W'(1);
                    if (first_chunk) threshold_d = thr_shadow_q;
                    if (!last_chunk) begin
                        chunk_d = chunk_q + CADDR_W'(1);
                        state_d = FETCH;
                    end else if (!last_neuron) begin
                        neuron_d = neuron_q + NADDR_W'(1);
                        chunk_d  = '0;
                        state_d  = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            neuron_q     <= '0;
            chunk_q      <= '0;
            wt_addr_q    <= '0;
            inputs_q     <= '0;
            weights_q    <= '0;
            valid_q      <= 1'b0;
            threshold_q  <= '0;
            thr_shadow_q <= '0;
        end else begin
            state_q      <= state_d;
            neuron_q     <= neuron_d;
            chunk_q      <= chunk_d;
            wt_addr_q    <= wt_addr_d;
            inputs_q     <= inputs_d;
            weights_q    <= weights_d;
            valid_q      <= valid_d;
            threshold_q  <= threshold_d;
            thr_shadow_q <= thr_shadow_d;
        end
    end
endmodule

// File: tb/tb_np_operand_feeder.sv
// tb_np_operand_feeder: randomized self-checking bench against a transfer-list model of the layer pass
module tb_np_operand_feeder;
    localparam int PI = 4;
    localparam int NI = 10;
    localparam int NN = 3;
    localparam int CH = 3;
    localparam int TOTAL = NN * CH;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic        act_wr_en = 1'b0;
    logic [1:0]  act_wr_addr = '0;
    logic [3:0]  act_wr_data = '0;
    logic        wt_rd_en;
    logic [3:0]  wt_addr;
    logic [3:0]  wt_rdata = '0;
    logic        thr_rd_en;
    logic [1:0]  thr_addr;
    logic [31:0] thr_rdata = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  inputs, weights;
    logic [31:0] threshold;
    logic        inputs_valid, weights_valid;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  act_m [CH];
    logic [31:0] thr_exp = '0;

    np_operand_feeder #(
        .PARALLEL_INPUTS(PI), .NUM_INPUTS(NI), .NUM_NEURONS(NN), .THRESH_W(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .act_wr_en(act_wr_en), .act_wr_addr(act_wr_addr), .act_wr_data(act_wr_data),
        .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_rdata(wt_rdata),
        .thr_rd_en(thr_rd_en), .thr_addr(thr_addr), .thr_rdata(thr_rdata),
        .rd_en(rd_en), .inputs(inputs), .weights(weights), .threshold(threshold),
        .inputs_valid(inputs_valid), .weights_valid(weights_valid)
    );

    always #5 clk = ~clk;

    // synchronous memories: word k holds k[3:0], thresholds 5,6,7; garbage when not read
    always @(posedge clk) begin
        wt_rdata  <= wt_rd_en ? wt_addr : 4'($urandom);
        thr_rdata <= thr_rd_en ? 32'd5 + 32'(thr_addr) : $urandom;
    end

    function automatic logic [3:0] exp_in(int c);
        logic [3:0] v;
        for (int i = 0; i < PI; i++) v[i] = (c * PI + i < NI) ? act_m[c][i] : 1'b0;
        return v;
    endfunction

    function automatic logic [3:0] exp_wt(int n, int c);
        logic [3:0] v;
        int word;
        word = (n * CH + c) % 16;
        for (int i = 0; i < PI; i++) v[i] = (c * PI + i < NI) ? word[i] : 1'b1;
        return v;
    endfunction

    task automatic load_act(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            act_wr_en   = 1'b1;
            act_wr_addr = 2'(i);
            act_wr_data = (i == 0) ? a0 : (i == 1) ? a1 : (i == 2) ? a2 : 4'($urandom);
        end
        @(negedge clk);
        act_wr_en = 1'b0;
        act_m[0] = a0;
        act_m[1] = a1;
        act_m[2] = a2;
    endtask

    task automatic run_pass(input int mode, input bit poke, input string tag);
        int k = 0, cyc = 1, last = 0, nv = 3, nf = 1, hold = 0, n, c;
        bit fin = 0, ev, eb, ed, ef, r;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 300) begin
            n  = k / CH;
            c  = k % CH;
            ev = (k < TOTAL) && (cyc >= nv);
            ef = (k < TOTAL) && (cyc == nf);
            ed = (k == TOTAL) && (cyc == last + 1);
            eb = (k < TOTAL) || ed;
            checks++;
            if (inputs_valid !== ev || weights_valid !== ev) begin
                errors++;
                $display("FAIL %s valid cyc=%0d got %b/%b exp %b", tag, cyc, inputs_valid, weights_valid, ev);
            end
            checks++;
            if (busy !== eb || done !== ed) begin
                errors++;
                $display("FAIL %s busy/done cyc=%0d got %b/%b exp %b/%b", tag, cyc, busy, done, eb, ed);
            end
            checks++;
            if (threshold !== thr_exp) begin
                errors++;
                $display("FAIL %s threshold cyc=%0d got %0d exp %0d", tag, cyc, threshold, thr_exp);
            end
            checks++;
            if (wt_rd_en !== ef || thr_rd_en !== (ef && c == 0)) begin
                errors++;
                $display("FAIL %s rd_strobes cyc=%0d got %b/%b exp %b/%b", tag, cyc, wt_rd_en, thr_rd_en, ef, ef && c == 0);
            end
            if (ef) begin
                checks++;
                if (wt_addr !== 4'(k) || (c == 0 && thr_addr !== 2'(n))) begin
                    errors++;
                    $display("FAIL %s addr cyc=%0d got %0d/%0d exp %0d/%0d", tag, cyc, wt_addr, thr_addr, k, n);
                end
            end
            if (ev) begin
                checks++;
                if (inputs !== exp_in(c) || weights !== exp_wt(n, c)) begin
                    errors++;
                    $display("FAIL %s data n=%0d c=%0d got %h/%h exp %h/%h", tag, n, c, inputs, weights, exp_in(c), exp_wt(n, c));
                end
            end
            r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : !(n == 1 && c == 1 && ev && hold < 5);
            if (mode == 2 && !r) hold++;
            rd_en     = r;
            start     = 1'b0;
            act_wr_en = 1'b0;
            if (poke && eb && !ed) begin
                start       = 1'($urandom_range(0, 1));
                act_wr_en   = 1'b1;
                act_wr_addr = 2'($urandom_range(0, 3));
                act_wr_data = 4'($urandom);
            end
            if (ev && r) begin
                last = cyc;
                k++;
                nf = cyc + 1;
                nv = cyc + 3;
                if (c == 0) thr_exp = 32'd5 + 32'(n);
            end
            fin = ed;
            @(negedge clk);
            cyc++;
        end
        rd_en = 1'b0;
        start = 1'b0;
        act_wr_en = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s timeout transfers=%0d exp %0d", tag, k, TOTAL);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after got busy=%b done=%b exp 0/0", tag, busy, done);
        end
        if (mode == 2) begin
            checks++;
            if (hold != 5) begin
                errors++;
                $display("FAIL %s backpressure_hold got %0d exp 5", tag, hold);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, wt_rd_en, thr_rd_en, inputs_valid, weights_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000", {busy, done, wt_rd_en, thr_rd_en, inputs_valid, weights_valid});
        end
        checks++;
        if (inputs !== 4'h0 || weights !== 4'h0 || threshold !== 32'h0 || wt_addr !== 4'h0 || thr_addr !== 2'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h %h exp zeros", inputs, weights, threshold, wt_addr, thr_addr);
        end
        rst = 1'b0;
        thr_exp = '0;
    endtask

    task automatic test_stream;
        load_act(4'hF, 4'h0, 4'h3);
        run_pass(0, 1'b0, "stream");
    endtask

    task automatic test_random_stream;
        for (int p = 0; p < 3; p++) begin
            load_act(4'($urandom), 4'($urandom), 4'($urandom));
            run_pass(1, 1'b0, "random");
        end
    endtask

    task automatic test_backpressure;
        load_act(4'($urandom), 4'($urandom), 4'($urandom));
        run_pass(2, 1'b0, "backpressure");
    endtask

    task automatic test_control;
        load_act(4'($urandom), 4'($urandom), 4'($urandom));
        run_pass(1, 1'b1, "busy_poke");
        run_pass(0, 1'b0, "readback");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rd_en = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || threshold !== 32'd6) begin
            errors++;
            $display("FAIL mid_pass got busy=%b thr=%0d exp 1/6", busy, threshold);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_en = 1'b0;
        checks++;
        if ({busy, done, wt_rd_en, thr_rd_en, inputs_valid, weights_valid} !== 6'b0 ||
            inputs !== 4'h0 || weights !== 4'h0 || threshold !== 32'h0 || wt_addr !== 4'h0 || thr_addr !== 2'h0) begin
            errors++;
            $display("FAIL reset_mid got ctrl=%b in=%h wt=%h thr=%0d exp all zero",
                     {busy, done, wt_rd_en, thr_rd_en, inputs_valid, weights_valid}, inputs, weights, threshold);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done got busy=%b done=%b exp 0/0", busy, done);
            end
        end
        thr_exp = '0;
        run_pass(0, 1'b0, "replay");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_random_stream();
        test_backpressure();
        test_control();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
